i2c_slave_core: RTL and testbench
=================================

# i2c_slave_core

I2C target (slave) that answers on a fixed 7-bit address and exposes a 16-byte register file to an external I2C master, plus a processor slot interface to the same bytes. It sits on the slot bus beside the I2C master core, so one board can act as both initiator and responder. Supported accesses: pointer-addressed byte writes and reads with auto-increment. No clock stretching; SCL is input-only.

## Interface
- SLAVE_ADDR, default 7'h50: 7-bit I2C address this target ACKs.
- clk  input  1  system clock; every register is clocked on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- cs  input  1  slot select.
- read  input  1  slot read strobe; unused, because rd_data is combinational.
- write  input  1  slot write strobe.
- reg_addr  input  5  slot register offset.
- wr_data  input  32  slot write data.
- rd_data  output  32  slot read data, combinational.
- scl  input  1  I2C clock from the bus.
- sda  inout  1  I2C data, open-drain: the block drives 0 or 'z, never 1.

## Operation
- Slot map:
  - reg_addr[4]=1: byte mem[reg_addr[3:0]]. Reads return {24'h0, byte}. Writes store wr_data[7:0].
  - reg_addr[4]=0: status. Reads return {20'h0, ptr[3:0], 6'h0, wr_flag, busy}. Writing wr_data[1]=1 clears wr_flag.
- Input sync: scl and sda each pass through 2-FF synchronizers. Edge detection uses one additional registered copy.
- Bus events:
  - START: synchronized sda falls while scl is high. Recognized in any state, including as a repeated START. Goes to RX_ADDR with the bit counter cleared.
  - STOP: synchronized sda rises while scl is high. Recognized in any state. Goes to IDLE and releases sda.
- States: IDLE, RX_ADDR, ACK_ADDR, RX_PTR, ACK_PTR, RX_DATA, ACK_DATA, TX_DATA, RX_MACK, WAIT_STOP.
- Reception: bits are sampled MSB first on each scl rising edge. The 8th sample completes a byte.
- ACK handling:
  - ACK is driven as sda=0 from the scl fall after the 8th bit until the next scl fall.
  - NACK means sda is left released.
- RX_ADDR, at byte complete:
  - addr[7:1]==SLAVE_ADDR and R/W=0: ACK_ADDR, then RX_PTR.
  - addr[7:1]==SLAVE_ADDR and R/W=1: ACK_ADDR, then TX_DATA.
  - Otherwise: NACK and go to WAIT_STOP.
- Write path:
  - RX_PTR: the byte's low nibble is loaded into ptr (bits 7:4 ignored). ACK_PTR follows, then RX_DATA.
  - RX_DATA: each byte is written to mem[ptr] on the completing scl rise. wr_flag is set and ptr increments modulo 16 (15 wraps to 0). ACK_DATA follows, then RX_DATA again.
- Read path:
  - TX_DATA: mem[ptr] is shifted out MSB first. Each bit is driven right after an scl fall; the first bit is driven at the fall that ends the address ACK. Bit 1 releases sda, bit 0 drives it low.
  - After 8 bits, ptr increments modulo 16, sda is released, and the state is RX_MACK.
  - RX_MACK: master ACK (sda=0 at scl rise) goes to TX_DATA with the next byte. Master NACK goes to WAIT_STOP.
- busy: 1 from an address match until STOP, or until a START that does not match.
- Collision: if an I2C byte write and a slot byte write hit the same byte in the same clk cycle, the I2C write wins. Different bytes are both written.
- A slot write to status does not change ptr.

## Timing
- Reset values:
  - sda released, state IDLE, ptr 0.
  - All mem bytes 8'h00; wr_flag 0, busy 0.
  - Synchronizers reset to 1.
- Reset mid-transaction releases sda immediately, because reset is asynchronous.
- Bus-event latency:
  - Input-to-event latency is 3 clk cycles.
  - sda changes at most 4 clk cycles after the synchronized scl fall.
  - Required: clk ≥ 16× scl; for example, 100 MHz clk supports up to 1 MHz SCL.
- Slot timing:
  - A slot write takes effect on the next clk edge.
  - rd_data reflects the new value on the following cycle.
- mem update from I2C: on the clk cycle the 8th scl rise is detected.
- Status timing:
  - wr_flag set and clear in the same cycle: the set wins.
  - busy asserts in the cycle the address match is detected.

## Configuration
- I2C_SLAVE_GEN_CALL_EN defined: address byte 8'h00 (general call, write) is ACKed and handled exactly as a write to SLAVE_ADDR. Address byte 8'h01 is NACKed.
- I2C_SLAVE_GEN_CALL_EN undefined: address 7'h00 is NACKed like any non-matching address.

## Test plan
- Write burst:
  - Stimulus: START, 8'hA0, ptr 8'h03, data 8'h11 8'h22, STOP.
  - Response: all four bytes ACKed; mem[3]=8'h11, mem[4]=8'h22; status reads ptr=5, wr_flag=1, busy=0.
- Read burst:
  - Stimulus: slot writes mem[14]=8'hC3 and mem[15]=8'h5A. Then START, 8'hA0, ptr 8'h0E, repeated START, 8'hA1; master ACKs byte 1, NACKs byte 2, STOP.
  - Response: bus reads 8'hC3 then 8'h5A; ptr wraps to 0.
- Address mismatch:
  - Stimulus: START, 8'h90, data 8'hFF, STOP.
  - Response: address NACKed; sda never driven; mem unchanged; busy stays 0.
- Collision:
  - Stimulus: slot write 8'h77 to mem[4] in the same clk as the I2C completes data 8'h22 to mem[4].
  - Response: mem[4]=8'h22.
- Reset mid-transaction:
  - Stimulus: assert reset during the 5th data bit of a read.
  - Response: sda is 'z within the same cycle; after reset, state IDLE and mem all 8'h00.
- General call:
  - Stimulus: START, 8'h00, ptr 8'h01, data 8'h9C, STOP.
  - Response with I2C_SLAVE_GEN_CALL_EN: ACKed and mem[1]=8'h9C.
  - Response without it: NACKed and mem[1]=8'h00.

Source files
------------

// File: rtl/i2c_slave_core_if.sv
// Processor slot bus shared by the I2C cores: select, strobes, offset and data.
interface i2c_slave_core_if;
   logic        cs;
   logic        read;
   logic        write;
   logic [4:0]  reg_addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;

   modport master (output cs, read, write, reg_addr, wr_data, input rd_data);
   modport slave  (input cs, read, write, reg_addr, wr_data, output rd_data);
endinterface

// File: rtl/i2c_slave_core.sv
// I2C target with a 16-byte register file shared with the processor slot bus.
// Define I2C_SLAVE_GEN_CALL_EN to also accept the general-call address (8'h00) as a write.
module i2c_slave_core #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
   input  logic            clk,
   input  logic            reset,
   i2c_slave_core_if.slave slot,
   input  logic            scl,
   inout  wire             sda
);
   localparam int unsigned MemDepth = 16;

   typedef enum logic [3:0] {
      IDLE, RX_ADDR, ACK_ADDR, RX_PTR, ACK_PTR, RX_DATA, ACK_DATA, TX_DATA, RX_MACK, WAIT_STOP
   } state_t;

   logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shift_q, shift_d;
   logic [7:0] tx_q, tx_d;
   logic [3:0] ptr_q, ptr_d;
   logic [7:0] mem_q [MemDepth];
   logic [7:0] mem_d [MemDepth];
   logic       rw_q, rw_d, mack_q, mack_d;
   logic       sda_oe_q, sda_oe_d, wr_flag_q, wr_flag_d, busy_q, busy_d;

   logic       scl_s, sda_s, scl_rise, scl_fall, bus_start, bus_stop;
   logic       byte_done, rx_state, addr_hit, gc_hit;
   logic [7:0] rx_byte;
   logic       unused_slot;

   assign scl_s     = scl_sync_q[1];
   assign sda_s     = sda_sync_q[1];
   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   assign bus_start = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign bus_stop  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
   assign rx_byte   = {shift_q, sda_s};
   assign byte_done = scl_rise && (bit_cnt_q == 3'd7);
   assign rx_state  = (state_q == RX_ADDR) || (state_q == RX_PTR) || (state_q == RX_DATA);

`ifdef I2C_SLAVE_GEN_CALL_EN
   assign gc_hit = (rx_byte == 8'h00);
`else
   assign gc_hit = 1'b0;
`endif
   assign addr_hit = (rx_byte[7:1] == SLAVE_ADDR) || gc_hit;

   // Open-drain: only ever pull low.
   assign sda = sda_oe_q ? 1'b0 : 1'bz;

   assign slot.rd_data = slot.reg_addr[4] ? {24'h0, mem_q[slot.reg_addr[3:0]]}
                                          : {20'h0, ptr_q, 6'h0, wr_flag_q, busy_q};
   assign unused_slot = ^{slot.read, slot.wr_data[31:8]};

   always_comb begin
      scl_sync_d = {scl_sync_q[0], scl};
      sda_sync_d = {sda_sync_q[0], sda};
      scl_prev_d = scl_s;
      sda_prev_d = sda_s;
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      ptr_d      = ptr_q;
      mem_d      = mem_q;
      rw_d       = rw_q;
      mack_d     = mack_q;
      sda_oe_d   = sda_oe_q;
      wr_flag_d  = wr_flag_q;
      busy_d     = busy_q;

      // Slot writes first so that a same-cycle I2C update below takes priority.
      if (slot.cs && slot.write) begin
         if (slot.reg_addr[4]) mem_d[slot.reg_addr[3:0]] = slot.wr_data[7:0];
         else if (slot.wr_data[1]) wr_flag_d = 1'b0;
      end

      if (scl_rise && rx_state) begin
         shift_d   = rx_byte[6:0];
         bit_cnt_d = bit_cnt_q + 3'd1;
      end

      case (state_q)
         RX_ADDR: if (byte_done) begin
            if (addr_hit) begin
               state_d = ACK_ADDR;
               rw_d    = rx_byte[0];
               busy_d  = 1'b1;
            end else begin
               state_d = WAIT_STOP;
               busy_d  = 1'b0;
            end
         end
         // ACK phase: first fall pulls sda low, second fall releases and moves on.
         ACK_ADDR, ACK_PTR, ACK_DATA: if (scl_fall) begin
            if (!sda_oe_q) begin
               sda_oe_d = 1'b1;
            end else begin
               sda_oe_d  = 1'b0;
               bit_cnt_d = 3'd0;
               if (state_q == ACK_ADDR && rw_q) begin
                  state_d  = TX_DATA;
                  tx_d     = mem_q[ptr_q];
                  sda_oe_d = ~mem_q[ptr_q][7];
               end else if (state_q == ACK_ADDR) begin
                  state_d = RX_PTR;
               end else begin
                  state_d = RX_DATA;
               end
            end
         end
         RX_PTR: if (byte_done) begin
            ptr_d   = rx_byte[3:0];
            state_d = ACK_PTR;
         end
         RX_DATA: if (byte_done) begin
            mem_d[ptr_q] = rx_byte;
            wr_flag_d    = 1'b1;
            ptr_d        = ptr_q + 4'd1;
            state_d      = ACK_DATA;
         end
         TX_DATA: if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
               sda_oe_d  = 1'b0;
               ptr_d     = ptr_q + 4'd1;
               bit_cnt_d = 3'd0;
               mack_d    = 1'b0;
               state_d   = RX_MACK;
            end else begin
               tx_d      = {tx_q[6:0], 1'b0};
               sda_oe_d  = ~tx_q[6];
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
         end
         RX_MACK: begin
            if (scl_rise) begin
               if (!sda_s) mack_d = 1'b1;
               else state_d = WAIT_STOP;
            end
            if (scl_fall && mack_q) begin
               mack_d    = 1'b0;
               bit_cnt_d = 3'd0;
               tx_d      = mem_q[ptr_q];
               sda_oe_d  = ~mem_q[ptr_q][7];
               state_d   = TX_DATA;
            end
         end
         default: ;
      endcase

      if (bus_start) begin
         state_d   = RX_ADDR;
         bit_cnt_d = 3'd0;
         sda_oe_d  = 1'b0;
         mack_d    = 1'b0;
      end
      if (bus_stop) begin
         state_d  = IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         state_q    <= IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 7'd0;
         tx_q       <= 8'd0;
         ptr_q      <= 4'd0;
         for (int i = 0; i < int'(MemDepth); i++) mem_q[i] <= 8'h00;
         rw_q       <= 1'b0;
         mack_q     <= 1'b0;
         sda_oe_q   <= 1'b0;
         wr_flag_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         ptr_q      <= ptr_d;
         mem_q      <= mem_d;
         rw_q       <= rw_d;
         mack_q     <= mack_d;
         sda_oe_q   <= sda_oe_d;
         wr_flag_q  <= wr_flag_d;
         busy_q     <= busy_d;
      end
   end
endmodule

// File: tb/tb_i2c_slave_core.sv
// Directed bench for i2c_slave_core: bit-banged I2C master plus slot-bus accesses.
module tb_i2c_slave_core;
   localparam int Q = 100;
   localparam int H = 200;

   logic clk = 1'b0;
   logic reset;
   logic scl_r;
   logic m_sda_low;
   wire  sda_w;
   logic watch, drove;
   int   n_tests = 0;
   int   n_fail  = 0;

   i2c_slave_core_if slot_if();

   pullup (sda_w);
   assign sda_w = m_sda_low ? 1'b0 : 1'bz;

   i2c_slave_core #(.SLAVE_ADDR(7'h50)) dut (
      .clk(clk), .reset(reset), .slot(slot_if), .scl(scl_r), .sda(sda_w)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (watch && !m_sda_low && sda_w !== 1'b1) drove = 1'b1;

   task automatic slot_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      slot_if.cs = 1'b1; slot_if.write = 1'b1; slot_if.reg_addr = a; slot_if.wr_data = d;
      @(negedge clk);
      slot_if.cs = 1'b0; slot_if.write = 1'b0;
   endtask

   task automatic slot_read(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk);
      slot_if.cs = 1'b1; slot_if.read = 1'b1; slot_if.reg_addr = a;
      #1 d = slot_if.rd_data;
      @(negedge clk);
      slot_if.cs = 1'b0; slot_if.read = 1'b0;
   endtask

   task automatic i2c_start();
      m_sda_low = 1'b0; #Q; scl_r = 1'b1; #Q; m_sda_low = 1'b1; #Q; scl_r = 1'b0; #Q;
   endtask

   task automatic i2c_stop();
      m_sda_low = 1'b1; #Q; scl_r = 1'b1; #Q; m_sda_low = 1'b0; #Q;
   endtask

   task automatic send_bit(input logic b);
      m_sda_low = ~b; #Q; scl_r = 1'b1; #H; scl_r = 1'b0; #Q;
   endtask

   task automatic ack_clock(output logic ack);
      m_sda_low = 1'b0; #Q; scl_r = 1'b1; #Q; ack = (sda_w === 1'b0); #Q; scl_r = 1'b0; #Q;
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      ack_clock(ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] b);
      m_sda_low = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         #Q; scl_r = 1'b1; #Q; b[i] = sda_w; #Q; scl_r = 1'b0;
      end
      #Q; m_sda_low = mack; #Q; scl_r = 1'b1; #H; scl_r = 1'b0; #Q; m_sda_low = 1'b0;
   endtask

   // Last data bit with its scl rise aligned so the slot write lands in the I2C write cycle.
   task automatic send_last_bit_collide(input logic b, input logic [4:0] a, input logic [7:0] d);
      m_sda_low = ~b; #Q;
      @(posedge clk); #1 scl_r = 1'b1;
      @(posedge clk); @(posedge clk);
      #1 slot_if.cs = 1'b1; slot_if.write = 1'b1; slot_if.reg_addr = a; slot_if.wr_data = {24'h0, d};
      @(posedge clk);
      #1 slot_if.cs = 1'b0; slot_if.write = 1'b0;
      #150; scl_r = 1'b0; #Q;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      n_tests++;
      if (sda_w !== 1'b1) begin $display("FAIL reset_sda: got %b expected 1", sda_w); n_fail++; end
      slot_read(5'h00, d);
      n_tests++;
      if (d !== 32'h0) begin $display("FAIL reset_status: got %h expected 00000000", d); n_fail++; end
      slot_read(5'h10, d);
      n_tests++;
      if (d !== 32'h0) begin $display("FAIL reset_mem0: got %h expected 00000000", d); n_fail++; end
   endtask

   task automatic test_write_burst();
      logic a0, a1, a2, a3;
      logic [31:0] d;
      i2c_start();
      write_byte(8'hA0, a0);
      slot_read(5'h00, d);
      n_tests++;
      if (d !== 32'h1) begin $display("FAIL wr_busy_mid: got %h expected 00000001", d); n_fail++; end
      write_byte(8'h03, a1);
      write_byte(8'h11, a2);
      write_byte(8'h22, a3);
      i2c_stop();
      n_tests++;
      if ({a0, a1, a2, a3} !== 4'b1111) begin
         $display("FAIL wr_acks: got %b expected 1111", {a0, a1, a2, a3}); n_fail++;
      end
      slot_read(5'h13, d);
      n_tests++;
      if (d !== 32'h11) begin $display("FAIL wr_mem3: got %h expected 00000011", d); n_fail++; end
      slot_read(5'h14, d);
      n_tests++;
      if (d !== 32'h22) begin $display("FAIL wr_mem4: got %h expected 00000022", d); n_fail++; end
      slot_read(5'h00, d);
      n_tests++;
      if (d !== 32'h502) begin $display("FAIL wr_status: got %h expected 00000502", d); n_fail++; end
      slot_write(5'h00, 32'h2);
      slot_read(5'h00, d);
      n_tests++;
      if (d !== 32'h500) begin $display("FAIL wr_flag_clear: got %h expected 00000500", d); n_fail++; end
   endtask

   task automatic test_read_burst();
      logic a0, a1, a2;
      logic [7:0] b0, b1;
      logic [31:0] d;
      slot_write(5'h1E, 32'hC3);
      slot_write(5'h1F, 32'h5A);
      i2c_start();
      write_byte(8'hA0, a0);
      write_byte(8'h0E, a1);
      i2c_start();
      write_byte(8'hA1, a2);
      read_byte(1'b1, b0);
      read_byte(1'b0, b1);
      i2c_stop();
      n_tests++;
      if ({a0, a1, a2} !== 3'b111) begin $display("FAIL rd_acks: got %b expected 111", {a0, a1, a2}); n_fail++; end
      n_tests++;
      if (b0 !== 8'hC3) begin $display("FAIL rd_byte0: got %h expected c3", b0); n_fail++; end
      n_tests++;
      if (b1 !== 8'h5A) begin $display("FAIL rd_byte1: got %h expected 5a", b1); n_fail++; end
      slot_read(5'h00, d);
      n_tests++;
      if (d !== 32'h0) begin $display("FAIL rd_ptr_wrap: got %h expected 00000000", d); n_fail++; end
   endtask

   task automatic test_addr_mismatch();
      logic a0, a1;
      logic [31:0] d;
      drove = 1'b0;
      watch = 1'b1;
      i2c_start();
      write_byte(8'h90, a0);
      slot_read(5'h00, d);
      n_tests++;
      if (d !== 32'h0) begin $display("FAIL mm_busy: got %h expected 00000000", d); n_fail++; end
      write_byte(8'hFF, a1);
      i2c_stop();
      watch = 1'b0;
      n_tests++;
      if ({a0, a1} !== 2'b00) begin $display("FAIL mm_nack: got %b expected 00", {a0, a1}); n_fail++; end
      n_tests++;
      if (drove !== 1'b0) begin $display("FAIL mm_sda_driven: got %b expected 0", drove); n_fail++; end
      slot_read(5'h1E, d);
      n_tests++;
      if (d !== 32'hC3) begin $display("FAIL mm_mem14: got %h expected 000000c3", d); n_fail++; end
   endtask

   task automatic test_collision();
      logic a0, a1, a2, a3;
      logic [7:0] v;
      logic [31:0] d;
      i2c_start();
      write_byte(8'hA0, a0);
      write_byte(8'h04, a1);
      v = 8'h22;
      for (int i = 7; i >= 1; i--) send_bit(v[i]);
      send_last_bit_collide(v[0], 5'h14, 8'h77);
      ack_clock(a2);
      v = 8'h33;
      for (int i = 7; i >= 1; i--) send_bit(v[i]);
      send_last_bit_collide(v[0], 5'h19, 8'h77);
      ack_clock(a3);
      i2c_stop();
      n_tests++;
      if ({a0, a1, a2, a3} !== 4'b1111) begin
         $display("FAIL col_acks: got %b expected 1111", {a0, a1, a2, a3}); n_fail++;
      end
      slot_read(5'h14, d);
      n_tests++;
      if (d !== 32'h22) begin $display("FAIL col_same_byte: got %h expected 00000022", d); n_fail++; end
      slot_read(5'h15, d);
      n_tests++;
      if (d !== 32'h33) begin $display("FAIL col_i2c_byte: got %h expected 00000033", d); n_fail++; end
      slot_read(5'h19, d);
      n_tests++;
      if (d !== 32'h77) begin $display("FAIL col_slot_byte: got %h expected 00000077", d); n_fail++; end
   endtask

   task automatic test_gen_call();
      logic a0, a1, a2;
      logic exp_ack;
      logic [31:0] exp_mem, exp_stat, d;
`ifdef I2C_SLAVE_GEN_CALL_EN
      exp_ack = 1'b1; exp_mem = 32'h9C; exp_stat = 32'h202;
`else
      exp_ack = 1'b0; exp_mem = 32'h00; exp_stat = 32'h600;
`endif
      slot_write(5'h00, 32'h2);
      i2c_start();
      write_byte(8'h00, a0);
      write_byte(8'h01, a1);
      write_byte(8'h9C, a2);
      i2c_stop();
      n_tests++;
      if (a0 !== exp_ack) begin $display("FAIL gc_ack: got %b expected %b", a0, exp_ack); n_fail++; end
      slot_read(5'h11, d);
      n_tests++;
      if (d !== exp_mem) begin $display("FAIL gc_mem1: got %h expected %h", d, exp_mem); n_fail++; end
      slot_read(5'h00, d);
      n_tests++;
      if (d !== exp_stat) begin $display("FAIL gc_status: got %h expected %h", d, exp_stat); n_fail++; end
   endtask

   task automatic test_reset_mid();
      logic a0, a1, a2;
      logic [31:0] d;
      slot_write(5'h17, 32'hF0);
      i2c_start();
      write_byte(8'hA0, a0);
      write_byte(8'h07, a1);
      i2c_start();
      write_byte(8'hA1, a2);
      n_tests++;
      if ({a0, a1, a2} !== 3'b111) begin $display("FAIL rm_acks: got %b expected 111", {a0, a1, a2}); n_fail++; end
      m_sda_low = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #Q; scl_r = 1'b1; #H; scl_r = 1'b0;
      end
      #Q;
      n_tests++;
      if (sda_w !== 1'b0) begin $display("FAIL rm_bit4_low: got %b expected 0", sda_w); n_fail++; end
      scl_r = 1'b1; #Q;
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_tests++;
      if (sda_w !== 1'b1) begin $display("FAIL rm_sda_release: got %b expected 1", sda_w); n_fail++; end
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      scl_r = 1'b0; #Q;
      i2c_stop();
      slot_read(5'h00, d);
      n_tests++;
      if (d !== 32'h0) begin $display("FAIL rm_status: got %h expected 00000000", d); n_fail++; end
      for (int i = 0; i < 16; i++) begin
         slot_read(5'(16 + i), d);
         n_tests++;
         if (d !== 32'h0) begin $display("FAIL rm_mem%0d: got %h expected 00000000", i, d); n_fail++; end
      end
   endtask

   initial begin
      reset = 1'b1;
      scl_r = 1'b1;
      m_sda_low = 1'b0;
      watch = 1'b0;
      drove = 1'b0;
      slot_if.cs = 1'b0; slot_if.read = 1'b0; slot_if.write = 1'b0;
      slot_if.reg_addr = 5'h0; slot_if.wr_data = 32'h0;
      repeat (5) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      repeat (4) @(posedge clk);
      test_reset();
      test_write_burst();
      test_read_burst();
      test_addr_mismatch();
      test_collision();
      test_gen_call();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
